// File: rtl/xor_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xor_regfile_pkg
// Purpose  : Shared types for the XOR-encoded multi-port register file.
// Revision : 1.0 - initial release
// ============================================================================
package xor_regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/xor_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : xor_regfile_if
// Purpose  : Write/read/clear bundle between a register-file user and the RAM.
// Revision : 1.0 - initial release
// ============================================================================
interface xor_regfile_if #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int N_WRITE = 2,
    parameter int N_READ  = 4
) ();
    localparam int c_addr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                               clear_req;
    logic                               ready;
    logic [N_WRITE-1:0]                 wen;
    logic [N_WRITE-1:0][c_addr_w-1:0]   waddr;
    logic [N_WRITE-1:0][WIDTH-1:0]      wdata;
    logic [N_READ-1:0][c_addr_w-1:0]    raddr;
    logic [N_READ-1:0][WIDTH-1:0]       rdata;

    modport master (
        output clear_req, wen, waddr, wdata, raddr,
        input  ready, rdata
    );

    modport slave (
        input  clear_req, wen, waddr, wdata, raddr,
        output ready, rdata
    );
endinterface
`default_nettype wire

// File: rtl/xor_bank.sv
`default_nettype none
// ============================================================================
// Module   : xor_bank
// Purpose  : DEPTH x WIDTH distributed RAM, one sync write port, one async read.
// Revision : 1.0 - initial release
// ============================================================================
module xor_bank #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [WIDTH-1:0]  i_wdata,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/xor_regfile.sv
`default_nettype none
// ============================================================================
// Module   : xor_regfile
// Purpose  : Multi-write multi-read register file from XOR-encoded RAM banks,
//            with clear sequencer, optional bypass and optional output register.
// Revision : 1.0 - initial release
// ============================================================================
module xor_regfile
    import xor_regfile_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 32,
    parameter int N_WRITE      = 2,
    parameter int N_READ       = 4,
    parameter int READ_LATENCY = 0,
    parameter int BYPASS       = 1
) (
    input  wire logic      clk,
    input  wire logic      reset,
    xor_regfile_if.slave   bus
);

    localparam int c_addr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [c_addr_w-1:0] addr_t;
    typedef logic [c_addr_w:0]   addr_ext_t;
    typedef logic [WIDTH-1:0]    word_t;

    localparam addr_t     c_last  = addr_t'(DEPTH - 1);
    localparam addr_ext_t c_depth = addr_ext_t'(DEPTH);

    state_t r_state;
    addr_t  r_ptr;
    logic   r_ready;

    logic                           w_clearing;
    logic [N_WRITE-1:0]             w_wvalid;
    logic [N_WRITE-1:0]             w_masked;
    logic [N_WRITE-1:0]             w_acc;
    logic [N_WRITE-1:0]             w_bank_we;
    addr_t                          w_bank_addr [N_WRITE];
    word_t                          w_bank_data [N_WRITE];
    word_t                          w_enc       [N_WRITE];
    // w_wrd[reader][source]: bank written by port source, read at waddr[reader]
    word_t                          w_wrd       [N_WRITE][N_WRITE];
    word_t                          w_rrd       [N_READ][N_WRITE];
    logic [N_READ-1:0]              w_rvalid;
    logic [N_READ-1:0][WIDTH-1:0]   w_rd;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_ptr == c_last) begin
                        r_state <= IDLE;
                        r_ptr   <= '0;
                        r_ready <= 1'b1;
                    end else begin
                        r_ptr   <= r_ptr + addr_t'(1);
                    end
                end
                IDLE: begin
                    if (bus.clear_req) begin
                        r_state <= CLEAR;
                        r_ptr   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_ptr   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready = r_ready;

    // ------------------------------------------------------------------
    // Write side: conflict mask, encoders, bank write controls
    // ------------------------------------------------------------------
    always_comb begin
        w_clearing = (r_state == CLEAR);
        for (int j = 0; j < N_WRITE; j++) begin
            w_wvalid[j] = ({1'b0, bus.waddr[j]} < c_depth);
        end
        for (int j = 0; j < N_WRITE; j++) begin
            w_masked[j] = 1'b0;
            for (int k = j + 1; k < N_WRITE; k++) begin
                if (bus.wen[k] && w_wvalid[k] && (bus.waddr[k] == bus.waddr[j])) begin
                    w_masked[j] = 1'b1;
                end
            end
            w_acc[j] = (r_state == IDLE) && !reset && bus.wen[j] &&
                       w_wvalid[j] && !w_masked[j];
            // Encode so the XOR of all banks at waddr yields wdata.
            w_enc[j] = bus.wdata[j];
            for (int i = 0; i < N_WRITE; i++) begin
                w_enc[j] = w_enc[j] ^ w_wrd[j][i];
            end
            w_bank_we[j]   = w_clearing || w_acc[j];
            w_bank_addr[j] = w_clearing ? r_ptr : bus.waddr[j];
            w_bank_data[j] = w_clearing ? '0 : w_enc[j];
        end
    end

    // ------------------------------------------------------------------
    // Bank array: every write port owns one copy per other write port
    // plus one copy per read port.
    // ------------------------------------------------------------------
    for (genvar j = 0; j < N_WRITE; j++) begin : g_src
        for (genvar i = 0; i < N_WRITE; i++) begin : g_wcopy
            if (i != j) begin : g_bank
                xor_bank #(
                    .WIDTH  (WIDTH),
                    .DEPTH  (DEPTH),
                    .ADDR_W (c_addr_w)
                ) u_bank (
                    .clk     (clk),
                    .i_we    (w_bank_we[j]),
                    .i_waddr (w_bank_addr[j]),
                    .i_wdata (w_bank_data[j]),
                    .i_raddr (bus.waddr[i]),
                    .o_rdata (w_wrd[i][j])
                );
            end else begin : g_self
                assign w_wrd[i][j] = '0;
            end
        end
        for (genvar r = 0; r < N_READ; r++) begin : g_rcopy
            xor_bank #(
                .WIDTH  (WIDTH),
                .DEPTH  (DEPTH),
                .ADDR_W (c_addr_w)
            ) u_bank (
                .clk     (clk),
                .i_we    (w_bank_we[j]),
                .i_waddr (w_bank_addr[j]),
                .i_wdata (w_bank_data[j]),
                .i_raddr (bus.raddr[r]),
                .o_rdata (w_rrd[r][j])
            );
        end
    end

    // ------------------------------------------------------------------
    // Read side: decoders, bypass, ready gating
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < N_READ; r++) begin
            w_rvalid[r] = ({1'b0, bus.raddr[r]} < c_depth);
            w_rd[r]     = '0;
            for (int j = 0; j < N_WRITE; j++) begin
                w_rd[r] = w_rd[r] ^ w_rrd[r][j];
            end
            if (!w_rvalid[r]) begin
                w_rd[r] = '0;
            end
            if (BYPASS != 0) begin
                // Ascending scan so the highest accepted port wins.
                for (int j = 0; j < N_WRITE; j++) begin
                    if (w_acc[j] && (bus.waddr[j] == bus.raddr[r])) begin
                        w_rd[r] = bus.wdata[j];
                    end
                end
            end
            if (r_state != IDLE) begin
                w_rd[r] = '0;
            end
        end
    end

    if (READ_LATENCY != 0) begin : g_lat1
        logic [N_READ-1:0][WIDTH-1:0] r_rdata;
        always_ff @(posedge clk) begin
            if (reset) begin
                r_rdata <= '0;
            end else begin
                r_rdata <= w_rd;
            end
        end
        assign bus.rdata = r_rdata;
    end else begin : g_lat0
        assign bus.rdata = w_rd;
    end

endmodule
`default_nettype wire

// File: tb/tb_xor_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_xor_regfile
// Purpose  : Directed self-checking bench for xor_regfile (two configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_xor_regfile;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    xor_regfile_if #(.WIDTH(32), .DEPTH(32), .N_WRITE(2), .N_READ(4)) a_if ();
    xor_regfile_if #(.WIDTH(32), .DEPTH(20), .N_WRITE(2), .N_READ(4)) b_if ();

    xor_regfile #(
        .WIDTH(32), .DEPTH(32), .N_WRITE(2), .N_READ(4),
        .READ_LATENCY(0), .BYPASS(1)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    xor_regfile #(
        .WIDTH(32), .DEPTH(20), .N_WRITE(2), .N_READ(4),
        .READ_LATENCY(1), .BYPASS(0)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; samples are taken 2 later.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Counts not-ready cycles starting with the current one.
    task automatic count_low(output int a_low, output int b_low);
        a_low = 0;
        b_low = 0;
        for (int i = 0; i < 45; i++) begin
            #2;
            if (!a_if.ready) a_low++;
            if (!b_if.ready) b_low++;
            nxt();
        end
    endtask

    logic [31:0] acc;
    int          a_low;
    int          b_low;
    int          low;

    initial begin
        n_checks = 0;
        n_errors = 0;
        clk      = 1'b0;
        reset    = 1'b1;
        a_if.clear_req = 1'b0; a_if.wen = '0; a_if.waddr = '0; a_if.wdata = '0; a_if.raddr = '0;
        b_if.clear_req = 1'b0; b_if.wen = '0; b_if.waddr = '0; b_if.wdata = '0; b_if.raddr = '0;

        repeat (2) @(posedge clk);
        #2;
        check("reset_ready_a", {31'd0, a_if.ready}, 32'd0);
        check("reset_rdata_b", b_if.rdata[0], 32'd0);
        reset = 1'b0;

        count_low(a_low, b_low);
        check("init_clear_cycles_a", a_low, 32'd32);
        check("init_clear_cycles_b", b_low, 32'd20);

        acc = '0;
        for (int k = 0; k < 8; k++) begin
            nxt();
            for (int r = 0; r < 4; r++) a_if.raddr[r] = 5'(4 * k + r);
            #2;
            for (int r = 0; r < 4; r++) acc = acc | a_if.rdata[r];
        end
        check("init_read_all_zero", acc, 32'd0);

        // Two ports, two addresses, same cycle
        nxt();
        a_if.wen = 2'b11;
        a_if.waddr[0] = 5'd5; a_if.wdata[0] = 32'hDEAD_BEEF;
        a_if.waddr[1] = 5'd9; a_if.wdata[1] = 32'h1234_5678;
        a_if.raddr[0] = 5'd5; a_if.raddr[1] = 5'd9;
        #2;
        check("bypass_5", a_if.rdata[0], 32'hDEAD_BEEF);
        nxt();
        a_if.wen = 2'b00;
        #2;
        check("read_5", a_if.rdata[0], 32'hDEAD_BEEF);
        check("read_9", a_if.rdata[1], 32'h1234_5678);

        // Same-address conflict: port1 wins
        nxt();
        a_if.wen = 2'b11;
        a_if.waddr[0] = 5'd3; a_if.wdata[0] = 32'h0000_AAAA;
        a_if.waddr[1] = 5'd3; a_if.wdata[1] = 32'h0000_5555;
        a_if.raddr[2] = 5'd3;
        #2;
        check("bypass_conflict_3", a_if.rdata[2], 32'h0000_5555);
        nxt();
        a_if.wen = 2'b00;
        #2;
        check("conflict_3", a_if.rdata[2], 32'h0000_5555);
        check("keep_5", a_if.rdata[0], 32'hDEAD_BEEF);

        // Overwrite through the opposite port from the original writer
        nxt();
        a_if.wen = 2'b11;
        a_if.waddr[0] = 5'd3; a_if.wdata[0] = 32'h0000_0077;
        a_if.waddr[1] = 5'd5; a_if.wdata[1] = 32'h0000_CAFE;
        nxt();
        a_if.wen = 2'b00;
        #2;
        check("rewrite_3", a_if.rdata[2], 32'h0000_0077);
        check("rewrite_5", a_if.rdata[0], 32'h0000_CAFE);
        check("keep_9", a_if.rdata[1], 32'h1234_5678);

        // Config B: registered read, no bypass
        nxt();
        b_if.wen = 2'b01;
        b_if.waddr[0] = 5'd7; b_if.wdata[0] = 32'h11;
        b_if.raddr[0] = 5'd7;
        nxt();
        b_if.wen = 2'b00;
        #2;
        check("rl1_old_value", b_if.rdata[0], 32'h0);
        nxt();
        #2;
        check("rl1_new_value", b_if.rdata[0], 32'h11);

        nxt();
        b_if.wen = 2'b11;
        b_if.waddr[0] = 5'd19; b_if.wdata[0] = 32'h19;
        b_if.waddr[1] = 5'd25; b_if.wdata[1] = 32'hBAD;
        b_if.raddr[0] = 5'd25; b_if.raddr[1] = 5'd19; b_if.raddr[2] = 5'd9;
        nxt();
        b_if.wen = 2'b00;
        nxt();
        #2;
        check("oob_read_25", b_if.rdata[0], 32'h0);
        check("last_addr_19", b_if.rdata[1], 32'h19);
        check("alias_9", b_if.rdata[2], 32'h0);

        nxt();
        b_if.wen = 2'b11;
        b_if.waddr[0] = 5'd12; b_if.wdata[0] = 32'hA;
        b_if.waddr[1] = 5'd12; b_if.wdata[1] = 32'hB;
        nxt();
        b_if.wen = 2'b00;
        b_if.raddr[0] = 5'd12;
        nxt();
        #2;
        check("b_conflict_12", b_if.rdata[0], 32'hB);

        // Fill A, then clear on request
        for (int k = 0; k < 16; k++) begin
            nxt();
            a_if.wen = 2'b11;
            a_if.waddr[0] = 5'(2 * k);     a_if.wdata[0] = 32'h100 + 32'(2 * k);
            a_if.waddr[1] = 5'(2 * k + 1); a_if.wdata[1] = 32'h101 + 32'(2 * k);
        end
        nxt();
        a_if.wen = 2'b00;
        a_if.raddr[0] = 5'd0; a_if.raddr[1] = 5'd31;
        #2;
        check("fill_0", a_if.rdata[0], 32'h100);
        check("fill_31", a_if.rdata[1], 32'h11F);

        nxt();
        a_if.clear_req = 1'b1;
        nxt();
        a_if.clear_req = 1'b0;
        a_if.raddr[0] = 5'd31;
        low = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) begin
                a_if.wen = 2'b01; a_if.waddr[0] = 5'd2; a_if.wdata[0] = 32'hFFFF;
            end else begin
                a_if.wen = 2'b00;
            end
            #2;
            if (i == 0) check("clear_rdata_forced", a_if.rdata[0], 32'h0);
            if (!a_if.ready) low++;
            nxt();
        end
        a_if.wen = 2'b00;
        check("req_clear_cycles", low, 32'd32);

        acc = '0;
        for (int k = 0; k < 8; k++) begin
            nxt();
            for (int r = 0; r < 4; r++) a_if.raddr[r] = 5'(4 * k + r);
            #2;
            for (int r = 0; r < 4; r++) acc = acc | a_if.rdata[r];
        end
        check("post_clear_all_zero", acc, 32'd0);

        // Reset in the middle of a clear
        nxt();
        a_if.clear_req = 1'b1;
        nxt();
        a_if.clear_req = 1'b0;
        repeat (17) nxt();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        count_low(a_low, b_low);
        check("reset_mid_clear_a", a_low, 32'd32);
        check("reset_mid_clear_b", b_low, 32'd20);

        a_if.wen = 2'b10;
        a_if.waddr[1] = 5'd17; a_if.wdata[1] = 32'h1717;
        nxt();
        a_if.wen = 2'b00;
        a_if.raddr[3] = 5'd17;
        #2;
        check("after_reset_write_17", a_if.rdata[3], 32'h1717);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xor_regfile.md
# xor_regfile

Parametrised multi-write, multi-read register file built from XOR-encoded single-write RAM banks. It supports any number of write ports without a live-value table, with selectable read latency, same-cycle write-to-read forwarding, and a hardware clear sequencer that zeroes every entry after reset or on request. It sits under the rename/physical register file and the issue-queue payload RAMs of the out-of-order core.

## Interface
- `WIDTH`, 32, bits per word
- `DEPTH`, 32, entries; need not be a power of two
- `N_WRITE`, 2, write ports (≥1)
- `N_READ`, 4, read ports (≥1)
- `READ_LATENCY`, 0, 0 = combinational read; 1 = registered read
- `BYPASS`, 1, 1 = reads observe same-cycle writes
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `clear_req`  in  1  start a full clear (sampled only while `ready`=1)
- `ready`  out  1  1 = IDLE; writes are accepted
- `wen`  in  N_WRITE  per-port write enable
- `waddr`  in  N_WRITE×clog2(DEPTH)  write addresses
- `wdata`  in  N_WRITE×WIDTH  write data
- `raddr`  in  N_READ×clog2(DEPTH)  read addresses
- `rdata`  out  N_READ×WIDTH  read data

## Operation
- Storage: bank[i][j] holds the encoded value written by port j and is read by write port i (i≠j) or read port r. The stored value at address a is the XOR over j of the bank-j copies.
- Write port j stores `wdata[j]` XOR (XOR of the other ports' banks at `waddr[j]`) into every bank-j copy.
- Conflicts: if several enabled ports hit the same address, the highest index wins. Lower ports are masked.
- Writes with `waddr` ≥ DEPTH are dropped. Reads with `raddr` ≥ DEPTH return 0.
- FSM states are CLEAR and IDLE.
  - Reset enters CLEAR with ptr=0. `clear_req`=1 in IDLE enters CLEAR with ptr=0 on the next edge.
  - In CLEAR, every bank copy at ptr is written with 0 and ptr increments. When ptr=DEPTH-1, the next state is IDLE.
  - A clear takes exactly DEPTH cycles.
  - `clear_req` during CLEAR is ignored.
  - `wen` during CLEAR is ignored, and the write is lost.
- `rdata` is forced to 0 while `ready`=0.
- With BYPASS=1, a read whose address matches an accepted same-cycle write returns that write's `wdata`, applying the highest-index rule. With BYPASS=0, it returns the old value.

## Timing
- Reset values: `ready`=0, ptr=0, state=CLEAR. With READ_LATENCY=1 the `rdata` registers reset to 0.
- `ready` rises DEPTH cycles after `reset` deasserts.
- Write latency: a write accepted at edge t is visible to a raddr presented in cycle t+1. With BYPASS=1 it is also visible in cycle t itself.
- READ_LATENCY=0: `rdata` is a combinational function of the current `raddr` and the current writes.
- READ_LATENCY=1: `rdata` at cycle t+1 equals what the READ_LATENCY=0 configuration would return at cycle t.
- Reset asserted mid-clear or mid-write restarts CLEAR at ptr=0. A write in the reset cycle is dropped.

## Structure
- Shared package `xor_regfile_pkg` holds the `state_t` enum {CLEAR, IDLE}.
- Each instance derives its own `addr_t`/`word_t` from the parameters; these are not placed in the package.
- Sub-module `xor_bank`: DEPTH×WIDTH distributed RAM with one synchronous write port and one asynchronous read port, with no reset.
- Instance count is N_WRITE×(N_WRITE−1)+N_WRITE×N_READ.
- Top level contains the conflict mask, encoders and decoders, clear FSM, bypass mux and optional output register.

## Test plan
- Reset held 2 cycles, then released, with DEPTH=32: `ready`=0 for 32 cycles then 1; reading all 32 addresses returns 0.
- Port0 writes addr 5 = 0xDEAD_BEEF while port1 writes addr 9 = 0x1234_5678 in the same cycle: next cycle raddr {5,9} returns {0xDEADBEEF, 0x12345678}.
- Port0 writes 0xAAAA and port1 writes 0x5555, both to addr 3: addr 3 reads 0x5555. With BYPASS=1 the same-cycle read of addr 3 also returns 0x5555.
- READ_LATENCY=1, BYPASS=0: write addr 7 = 0x11 in cycle t with raddr 7 in cycle t; `rdata` at t+1 shows the old value 0. A repeated read shows 0x11 one cycle later.
- Fill addrs 0..31 with nonzero values, pulse `clear_req`:
  - `ready` drops for exactly 32 cycles.
  - A write issued during the clear is dropped.
  - Afterwards all addresses read 0.
- `reset` asserted at ptr=17 of a clear: ptr restarts at 0, and `ready` rises 32 cycles after release. DEPTH=20 variant: write to addr 25 is dropped and a read of 25 returns 0.
